wtree_mul_pipe: RTL and testbench

Parametrised pipelined multiplier that replaces the single-shot 64-column Wallace tree with a streaming unit.
- Radix-4 Booth partial-product generation feeds a 3:2 carry-save Wallace reduction split across PIPE_STAGES register stages.
- A final carry-propagate add produces the full double-width product.
- Supports signed and unsigned operands per transaction, valid/ready flow control at both ends, and a synchronous flush.
- Sits between the ALU issue stage and writeback in the integer datapath.

---
 rtl/wtree_mul_pipe.sv | 180 ++++++++++++++++++
 tb/tb_wtree_mul_pipe.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wtree_mul_pipe.sv
// Streaming radix-4 Booth / Wallace-tree multiplier with valid/ready flow control.
// Booth rows and carry-save levels are spread over PIPE_STAGES-1 register stages.
// The last stage does the carry-propagate add.
module wtree_mul_pipe #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned PIPE_STAGES = 3
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_signed,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_product,
   output logic                 busy
);

   localparam int unsigned PW         = 2 * WIDTH;
   localparam int unsigned NROWS      = WIDTH / 2 + 1;
   localparam int unsigned RED_STAGES = (PIPE_STAGES > 1) ? PIPE_STAGES - 1 : 1;

   typedef logic [NROWS-1:0][PW-1:0] rows_t;

   // Number of live rows after lv carry-save levels.
   function automatic int unsigned rows_at(input int unsigned lv);
      int unsigned n;
      n = NROWS;
      for (int unsigned i = 0; i < lv; i++)
         if (n > 2) n = (n / 3) * 2 + n % 3;
      return n;
   endfunction

   // Levels needed to bring the row count down to sum + carry.
   function automatic int unsigned count_levels(input int unsigned rows);
      int unsigned n;
      int unsigned l;
      n = rows;
      l = 0;
      for (int unsigned i = 0; i < rows; i++)
         if (n > 2) begin
            n = (n / 3) * 2 + n % 3;
            l++;
         end
      return l;
   endfunction

   localparam int unsigned LEVELS = count_levels(NROWS);

   // First level past the end of reduction stage k (levels shared out evenly).
   function automatic int unsigned lv_end(input int unsigned k);
      return (LEVELS * k + RED_STAGES - 1) / RED_STAGES;
   endfunction

   // Radix-4 Booth rows; a negative row's +1 rides in the empty LSBs of the next row.
   // The top digit is never negative, so the last row never needs a hot bit.
   function automatic rows_t booth_rows(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b,
                                        input logic             sgn);
      logic [WIDTH+1:0] ae;
      logic [WIDTH+2:0] bl;
      logic [PW-1:0]    ax;
      logic [PW-1:0]    m;
      logic [2:0]       t;
      logic             one, two, neg;
      rows_t            r;
      ae = {{2{sgn & a[WIDTH-1]}}, a};
      bl = {{2{sgn & b[WIDTH-1]}}, b, 1'b0};
      ax = {{(PW-WIDTH-2){ae[WIDTH+1]}}, ae};
      r  = '0;
      for (int unsigned i = 0; i < NROWS; i++) begin
         t   = bl[2*i+2 -: 3];
         one = t[1] ^ t[0];
         two = (t == 3'b011) || (t == 3'b100);
         neg = t[2] & ~(t[1] & t[0]);
         m   = one ? ax : (two ? (ax << 1) : '0);
         if (neg) m = ~m;
         r[i] = r[i] | (m << (2*i));
         if (neg && (i + 1 < NROWS)) r[i+1] = PW'(1) << (2*i);
      end
      return r;
   endfunction

   // One 3:2 level over the first n rows; leftover rows pass straight through.
   function automatic rows_t csa_level(input rows_t r, input int unsigned n);
      rows_t         o;
      int unsigned   k;
      logic [PW-1:0] x, y, z;
      o = '0;
      k = 0;
      for (int unsigned g = 0; g < n / 3; g++) begin
         x      = r[3*g];
         y      = r[3*g+1];
         z      = r[3*g+2];
         o[k]   = x ^ y ^ z;
         o[k+1] = ((x & y) | (x & z) | (y & z)) << 1;
         k      = k + 2;
      end
      for (int unsigned j = (n / 3) * 3; j < n; j++) begin
         o[k] = r[j];
         k    = k + 1;
      end
      return o;
   endfunction

   // Apply carry-save levels lo..hi-1.
   function automatic rows_t reduce(input rows_t r, input int unsigned lo,
                                    input int unsigned hi);
      rows_t t;
      t = r;
      for (int unsigned lv = lo; lv < hi; lv++) t = csa_level(t, rows_at(lv));
      return t;
   endfunction

   // Reduce through the last level and return {carry, sum}.
   function automatic logic [2*PW-1:0] reduce_pair(input rows_t r, input int unsigned lo,
                                                   input int unsigned hi);
      rows_t t;
      t = reduce(r, lo, hi);
      return {t[1], t[0]};
   endfunction

   logic                   adv;
   logic [PIPE_STAGES-1:0] vld_q;
   logic [PW-1:0]          prod_q;
   logic [PW-1:0]          fin_sum;
   logic [PW-1:0]          fin_carry;

   assign out_valid   = vld_q[PIPE_STAGES-1];
   assign adv         = out_ready | ~out_valid;
   assign in_ready    = adv;
   assign busy        = |vld_q;
   assign out_product = prod_q;

   // Per-stage valid bits: shift on advance, cleared by flush.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)   vld_q <= '0;
      else if (flush) vld_q <= '0;
      else if (adv)   vld_q <= PIPE_STAGES'({vld_q, in_valid});
   end

   if (PIPE_STAGES == 1) begin : g_single
      assign {fin_carry, fin_sum} = reduce_pair(booth_rows(in_a, in_b, in_signed), 0, LEVELS);
   end else begin : g_multi
      for (genvar s = 0; s < PIPE_STAGES - 1; s++) begin : g_red
         rows_t d;
         if (s == 0) begin : g_src
            assign d = booth_rows(in_a, in_b, in_signed);
         end else begin : g_src
            assign d = g_red[s-1].g_reg.q;
         end
         if (s < PIPE_STAGES - 2) begin : g_reg
            rows_t q;
            // Intermediate carry-save rows for this stage's share of levels.
            always_ff @(posedge clk or negedge resetn) begin
               if (!resetn)  q <= '0;
               else if (adv) q <= reduce(d, lv_end(s), lv_end(s + 1));
            end
         end else begin : g_reg
            logic [2*PW-1:0] q;
            // Final sum/carry pair handed to the adder stage.
            always_ff @(posedge clk or negedge resetn) begin
               if (!resetn)  q <= '0;
               else if (adv) q <= reduce_pair(d, lv_end(s), lv_end(s + 1));
            end
         end
      end
      assign {fin_carry, fin_sum} = g_red[PIPE_STAGES-2].g_reg.q;
   end

   // Carry-propagate add into the output register; holds while stalled.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)  prod_q <= '0;
      else if (adv) prod_q <= fin_sum + fin_carry;
   end

endmodule

// File: tb/tb_wtree_mul_pipe.sv
// Bench for wtree_mul_pipe: directed table, stall/flush/reset sequences,
// plus random streams on two extra width/depth configurations.
module tb_wtree_mul_pipe;

   localparam int unsigned W = 32;
   localparam int unsigned P = 3;

   logic          clk = 1'b0;
   logic          resetn;
   logic          in_valid, in_ready, in_signed, flush, out_valid, out_ready, busy;
   logic [W-1:0]  in_a, in_b;
   logic [63:0]   out_product;

   logic          man_rdy, rnd_mode, rnd_rdy;
   assign out_ready = rnd_mode ? rnd_rdy : man_rdy;

   // Small configurations: 8-bit single stage, 16-bit four stages.
   logic          s1_in_valid, s1_in_ready, s1_in_signed, s1_out_valid, s1_busy;
   logic [7:0]    s1_in_a, s1_in_b;
   logic [15:0]   s1_out_product;
   logic          s2_in_valid, s2_in_ready, s2_in_signed, s2_out_valid, s2_busy;
   logic [15:0]   s2_in_a, s2_in_b;
   logic [31:0]   s2_out_product;
   logic          sm_on;

   always #5 clk = ~clk;

   wtree_mul_pipe #(.WIDTH(W), .PIPE_STAGES(P)) u_dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .in_signed(in_signed), .in_a(in_a), .in_b(in_b), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product), .busy(busy));

   wtree_mul_pipe #(.WIDTH(8), .PIPE_STAGES(1)) u_s1 (
      .clk(clk), .resetn(resetn), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
      .in_signed(s1_in_signed), .in_a(s1_in_a), .in_b(s1_in_b), .flush(1'b0),
      .out_valid(s1_out_valid), .out_ready(1'b1), .out_product(s1_out_product), .busy(s1_busy));

   wtree_mul_pipe #(.WIDTH(16), .PIPE_STAGES(4)) u_s2 (
      .clk(clk), .resetn(resetn), .in_valid(s2_in_valid), .in_ready(s2_in_ready),
      .in_signed(s2_in_signed), .in_a(s2_in_a), .in_b(s2_in_b), .flush(1'b0),
      .out_valid(s2_out_valid), .out_ready(1'b1), .out_product(s2_out_product), .busy(s2_busy));

   int n_run = 0;
   int n_fail = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rnd_rdy <= ($urandom_range(0, 3) != 0);

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name, input logic [63:0] got);
      n_run++;
      n_fail++;
      $display("FAIL %s: got product %0h with nothing outstanding (cycle %0d)", name, got, cyc);
   endtask

   // Reference: extend both operands to 64 bits, multiply, keep 2*w bits.
   function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                         input int w, input bit s);
      logic [63:0] m, m2, ae, be;
      m  = (w >= 64) ? '1 : ((64'(1) << w) - 64'(1));
      m2 = (2 * w >= 64) ? '1 : ((64'(1) << (2 * w)) - 64'(1));
      ae = a & m;
      be = b & m;
      if (s && a[w-1]) ae = ae | ~m;
      if (s && b[w-1]) be = be | ~m;
      return (ae * be) & m2;
   endfunction

   // Operand mix biased towards 0, 1, MIN, MAX and all-ones.
   function automatic logic [63:0] pick(input int w);
      logic [63:0] r;
      r = {$urandom, $urandom};
      case ($urandom_range(0, 6))
         0: r = 64'd0;
         1: r = 64'd1;
         2: r = 64'(1) << (w - 1);
         3: r = (64'(1) << (w - 1)) - 64'(1);
         4: r = '1;
         default: ;
      endcase
      return r;
   endfunction

   typedef struct {
      logic [63:0] p;
      int          c;
      bit          lat;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        q1[$];
   exp_t        q2[$];
   exp_t        mon_e, m1_e, m2_e;
   logic [63:0] exp_cur, s1_exp, s2_exp;
   bit          lat_chk;

   // Main scoreboard: compare outputs in order, then log this cycle's acceptance.
   always @(negedge clk) begin
      if (resetn) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) unexpected("main_extra_out", out_product);
            else begin
               mon_e = exp_q.pop_front();
               check("main_product", out_product, mon_e.p);
               if (mon_e.lat) check("main_latency", 64'(cyc - mon_e.c), 64'(P));
            end
         end
         if (in_valid && in_ready && !flush) exp_q.push_back('{exp_cur, cyc, lat_chk});
      end
   end

   // Scoreboards for the small configurations.
   always @(negedge clk) begin
      if (resetn && sm_on) begin
         if (s1_out_valid) begin
            if (q1.size() == 0) unexpected("s1_extra_out", 64'(s1_out_product));
            else begin
               m1_e = q1.pop_front();
               check("s1_product", 64'(s1_out_product), m1_e.p);
               check("s1_latency", 64'(cyc - m1_e.c), 64'd1);
            end
         end
         if (s1_in_valid && s1_in_ready) q1.push_back('{s1_exp, cyc, 1'b1});
         if (s2_out_valid) begin
            if (q2.size() == 0) unexpected("s2_extra_out", 64'(s2_out_product));
            else begin
               m2_e = q2.pop_front();
               check("s2_product", 64'(s2_out_product), m2_e.p);
               check("s2_latency", 64'(cyc - m2_e.c), 64'd4);
            end
         end
         if (s2_in_valid && s2_in_ready) q2.push_back('{s2_exp, cyc, 1'b1});
      end
   end

   // Present one operand pair and hold it until accepted (called just after a posedge).
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [63:0] e);
      bit ok;
      in_a = a; in_b = b; in_signed = s; exp_cur = e; in_valid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 64 && !ok; t++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
      end
      if (!ok) check("send_timeout_in_ready", 64'd0, 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic wait_drain(input int max_cyc);
      for (int t = 0; t < max_cyc && exp_q.size() != 0; t++) @(negedge clk);
      check("drain_outstanding", 64'(exp_q.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [63:0] p;
   } vec_t;

   vec_t vecs[14];
   int   vcount;

   initial begin
      vecs[0]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
      vecs[1]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001};
      vecs[2]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
      vecs[3]  = '{32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA};
      vecs[4]  = '{32'h8000_0000, 32'h0000_0002, 1'b0, 64'h0000_0001_0000_0000};
      vecs[5]  = '{32'h0000_0000, 32'h1234_5678, 1'b0, 64'h0000_0000_0000_0000};
      vecs[6]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 64'h3FFF_FFFF_0000_0001};
      vecs[7]  = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000};
      vecs[8]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[9]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 64'h0000_0000_FFFF_FFFF};
      vecs[10] = '{32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 64'h0000_0000_FFFE_0001};
      vecs[11] = '{32'hFFFF_FFF9, 32'h0000_0006, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6};
      vecs[12] = '{32'h0001_0000, 32'hFFFF_0000, 1'b1, 64'hFFFF_FFFF_0000_0000};
      vecs[13] = '{32'hAAAA_AAAA, 32'h0000_0003, 1'b0, 64'h0000_0001_FFFF_FFFE};

      resetn = 1'b0; in_valid = 1'b0; in_signed = 1'b0; in_a = '0; in_b = '0;
      flush = 1'b0; man_rdy = 1'b0; rnd_mode = 1'b0; lat_chk = 1'b0; exp_cur = '0;
      s1_in_valid = 1'b0; s1_in_signed = 1'b0; s1_in_a = '0; s1_in_b = '0; s1_exp = '0;
      s2_in_valid = 1'b0; s2_in_signed = 1'b0; s2_in_a = '0; s2_in_b = '0; s2_exp = '0;
      sm_on = 1'b0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_product", out_product, 64'd0);
      resetn = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;

      // Directed table, back to back with mixed modes; latency checked.
      man_rdy = 1'b1;
      lat_chk = 1'b1;
      for (int i = 0; i < 14; i++) send(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].p);
      in_valid = 1'b0;
      wait_drain(20);

      // Random operands against the model with a randomly stalling consumer.
      lat_chk  = 1'b0;
      rnd_mode = 1'b1;
      for (int i = 0; i < 150; i++) begin
         logic [63:0] ra, rb;
         logic        rs;
         ra = pick(32); rb = pick(32); rs = 1'($urandom_range(0, 1));
         send(32'(ra), 32'(rb), rs, model(ra, rb, 32, rs));
      end
      in_valid = 1'b0;
      wait_drain(200);
      rnd_mode = 1'b0;

      // Backpressure: fill the pipe with out_ready low and hold the head.
      man_rdy = 1'b0;
      send(32'd3, 32'd5, 1'b0, 64'd15);
      send(32'h100, 32'h100, 1'b0, 64'h10000);
      send(32'hFFFF_FFFF, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB);
      in_a = 32'd9; in_b = 32'd9; in_signed = 1'b0; exp_cur = 64'd81; in_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("stall_in_ready", 64'(in_ready), 64'd0);
         check("stall_out_valid", 64'(out_valid), 64'd1);
         check("stall_hold_product", out_product, 64'd15);
      end
      check("stall_busy", 64'(busy), 64'd1);
      @(posedge clk); #1;
      man_rdy = 1'b1;
      send(32'd9, 32'd9, 1'b0, 64'd81);
      in_valid = 1'b0;
      wait_drain(20);

      // Flush with three in flight and a new input offered in the flush cycle.
      send(32'd2, 32'd3, 1'b0, 64'd6);
      send(32'd4, 32'd5, 1'b0, 64'd20);
      send(32'd10, 32'd10, 1'b0, 64'd100);
      flush = 1'b1; in_a = 32'd5; in_b = 32'd5; exp_cur = 64'd25; in_valid = 1'b1;
      @(negedge clk);
      check("flush_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("flush_busy", 64'(busy), 64'd0);
      check("flush_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      lat_chk = 1'b1;
      send(32'd7, 32'd6, 1'b0, 64'd42);
      in_valid = 1'b0;
      wait_drain(10);

      // Asynchronous reset between edges with two in flight.
      lat_chk = 1'b0;
      send(32'd3, 32'd3, 1'b0, 64'd9);
      send(32'd4, 32'd4, 1'b0, 64'd16);
      in_valid = 1'b0;
      check("pre_reset_busy", 64'(busy), 64'd1);
      #2;
      resetn = 1'b0;
      #1;
      check("areset_out_valid", 64'(out_valid), 64'd0);
      check("areset_busy", 64'(busy), 64'd0);
      exp_q.delete();
      @(negedge clk); #2;
      resetn = 1'b1;
      vcount = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (out_valid) vcount++;
      end
      check("post_reset_outputs", 64'(vcount), 64'd0);
      check("post_reset_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;

      // Random streams on the 8-bit/1-stage and 16-bit/4-stage configurations.
      sm_on = 1'b1;
      for (int i = 0; i < 300; i++) begin
         logic [63:0] a1, b1, a2, b2;
         logic        t1, t2;
         a1 = pick(8);  b1 = pick(8);  t1 = 1'($urandom_range(0, 1));
         a2 = pick(16); b2 = pick(16); t2 = 1'($urandom_range(0, 1));
         s1_in_a = 8'(a1);  s1_in_b = 8'(b1);  s1_in_signed = t1;
         s1_exp  = model(a1, b1, 8, t1);
         s1_in_valid = ($urandom_range(0, 4) != 0);
         s2_in_a = 16'(a2); s2_in_b = 16'(b2); s2_in_signed = t2;
         s2_exp  = model(a2, b2, 16, t2);
         s2_in_valid = ($urandom_range(0, 4) != 0);
         @(posedge clk); #1;
      end
      s1_in_valid = 1'b0;
      s2_in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("s1_drain", 64'(q1.size()), 64'd0);
      check("s2_drain", 64'(q2.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
